// File: rtl/elpis_print_buffer.sv
// elpis_print_buffer: buffers 32-bit print words from the core in a small FIFO
// and exposes them to a Wishbone classic host through DATA/STATUS/CTRL registers.
// Optional feature: define ELPIS_PRINT_IRQ_EN to drive irq_o from irq_enable && !empty.
module elpis_print_buffer #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        print_valid,
    input  logic [31:0] print_data,
    output logic        print_ready,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        print_pending,
    output logic        irq_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            stalled_reg, irq_enable_reg;
    logic [31:0]     dat_reg, dat_next;
    logic [31:0]     status_word, rdata_sel;

    logic            empty, full, hit, take, push, pop, flush, clear_stall, ctrl_wr, stall_event;
    logic [1:0]      offset;

    // Byte selects, upper write-data bits and byte-lane address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{wbs_sel_i, wbs_dat_i[31:3], wbs_adr_i[1:0]};

    assign empty         = (count_reg == '0);
    assign full          = (count_reg == FULL_COUNT);
    assign print_ready   = !full;
    assign print_pending = !empty;
    assign wbs_ack_o     = (state_reg == ST_ACK);
    assign wbs_dat_o     = dat_reg;

    assign hit         = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign offset      = wbs_adr_i[3:2];
    assign push        = print_valid && !full;
    assign stall_event = print_valid && !full ? 1'b0 : print_valid;
    assign pop         = take && !wbs_we_i && (offset == 2'd0) && !empty;
    assign ctrl_wr     = take && wbs_we_i && (offset == 2'd2);
    assign flush       = ctrl_wr && wbs_dat_i[0];
    assign clear_stall = ctrl_wr && wbs_dat_i[1];

    // Slave FSM: a hit in IDLE commits the register action and acks on the next cycle.
    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (hit) begin
                    state_next = ST_ACK;
                    take       = 1'b1;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Assemble STATUS and select read data by register offset.
    always_comb begin
        status_word           = 32'h0;
        status_word[0]        = empty;
        status_word[1]        = full;
        status_word[2]        = stalled_reg;
        status_word[3]        = irq_enable_reg;
        status_word[8 +: CW]  = count_reg;
        rdata_sel             = 32'h0;
        case (offset)
            2'd0:    rdata_sel = empty ? 32'h0 : mem[rd_ptr_reg];
            2'd1:    rdata_sel = status_word;
            2'd2:    rdata_sel = {29'b0, irq_enable_reg, 2'b0};
            default: rdata_sel = 32'h0;
        endcase
        dat_next = (take && !wbs_we_i) ? rdata_sel : 32'h0;
    end

    // FIFO storage; not reset, a flush only rewinds the pointers.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= print_data;
        end
    end

    // Pointers, occupancy, sticky stall flag, control bits and the read-data register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg      <= ST_IDLE;
            dat_reg        <= 32'h0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            stalled_reg    <= 1'b0;
            irq_enable_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            dat_reg   <= dat_next;
            if (flush) begin
                // A flush discards any word pushed in the same cycle.
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + CW'(1);
                    2'b01:   count_reg <= count_reg - CW'(1);
                    default: count_reg <= count_reg;
                endcase
            end
            // A stall seen in the same cycle as a clear is kept so it is not lost.
            if (stall_event) begin
                stalled_reg <= 1'b1;
            end else if (clear_stall) begin
                stalled_reg <= 1'b0;
            end
            if (ctrl_wr) begin
                irq_enable_reg <= wbs_dat_i[2];
            end
        end
    end

`ifdef ELPIS_PRINT_IRQ_EN
    logic irq_reg;

    // Interrupt follows the registered enable/occupancy state one cycle later.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= irq_enable_reg && !empty;
        end
    end

    assign irq_o = irq_reg;
`else
    assign irq_o = 1'b0;
`endif

endmodule
